// File: rtl/snn_sched_pkg.sv
// Shared definitions for the per-beat spike scheduler.
//   state_t   : scheduler FSM states
//   CLS_*     : class neuron indices (CLS_NONE marks "no confident class")
//   max3      : helper used to size the shared phase counter
package snn_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      OBSERVE,
      DECIDE,
      REPORT
   } state_t;

   localparam int unsigned CLS_W = 4;

   localparam logic [CLS_W-1:0] CLS_V    = 4'd0;
   localparam logic [CLS_W-1:0] CLS_S    = 4'd1;
   localparam logic [CLS_W-1:0] CLS_SA   = 4'd2;
   localparam logic [CLS_W-1:0] CLS_ST   = 4'd3;
   localparam logic [CLS_W-1:0] CLS_N    = 4'd4;
   localparam logic [CLS_W-1:0] CLS_WT   = 4'd5;
   localparam logic [CLS_W-1:0] CLS_NT   = 4'd6;
   localparam logic [CLS_W-1:0] CLS_WB   = 4'd7;
   localparam logic [CLS_W-1:0] CLS_NB   = 4'd8;
   localparam logic [CLS_W-1:0] CLS_NONE = 4'hF;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/snn_spike_counter.sv
// One saturating spike counter for a single class neuron.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (start of a new beat)
//   en       : count one spike this cycle
//   cnt      : current count, holds at all-ones instead of wrapping
module snn_spike_counter #(
   parameter int unsigned CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/snn_beat_sched.sv
// Per-beat scheduler for the 9-neuron AdEx arrhythmia classifier.
// Each beat: hold neurons in reset (SETTLE), count spikes per class over a
// fixed window (OBSERVE), pick the winner by sequential argmax (DECIDE) and
// offer it on a valid/ready port (REPORT).
//   beat_start   : 1-cycle pulse, new beat features valid
//   spike_in     : class neuron spikes, bit i = class i
//   neuron_rst   : class neuron reset, high during SETTLE
//   feat_hold    : freeze encoder features during SETTLE and OBSERVE
//   busy         : high in every state except IDLE
//   class_valid / class_ready : result handshake
//   class_id     : winning class, CLS_NONE when too few spikes
//   class_count  : spike count of the winner
//   class_margin : winner minus runner-up (only with SNN_SCHED_MARGIN_EN)
//   overrun      : sticky, a beat_start arrived while busy
// Build option: define SNN_SCHED_MARGIN_EN to build the runner-up tracker;
// otherwise class_margin is tied to zero.
module snn_beat_sched
   import snn_sched_pkg::*;
#(
   parameter int unsigned N_CLASS    = 9,
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned WIN_CYCLES = 1024,
   parameter int unsigned CNT_W      = 12,
   parameter int unsigned MIN_SPIKES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               beat_start,
   input  logic [N_CLASS-1:0] spike_in,
   output logic               neuron_rst,
   output logic               feat_hold,
   output logic               busy,
   output logic               class_valid,
   input  logic               class_ready,
   output logic [3:0]         class_id,
   output logic [CNT_W-1:0]   class_count,
   output logic [CNT_W-1:0]   class_margin,
   output logic               overrun
);

   localparam int unsigned PH_MAX = max3(SETTLE_CYC, WIN_CYCLES, N_CLASS);
   localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_SPIKES);

   state_t             state, nxt;
   logic [PH_W-1:0]    phase;
   logic               phase_last;
   logic               cnt_clr;
   logic [N_CLASS-1:0] cnt_en;
   logic [CNT_W-1:0]   cnt [N_CLASS];

   logic [CNT_W-1:0]   cur;
   logic [CNT_W-1:0]   best, best_n;
   logic [CLS_W-1:0]   best_idx, best_idx_n;
   logic               win_ok;

`ifdef SNN_SCHED_MARGIN_EN
   logic [CNT_W-1:0]   second, second_n;
`endif

   // Spike counters
   for (genvar g = 0; g < N_CLASS; g++) begin : g_cnt
      assign cnt_en[g] = (state == OBSERVE) && spike_in[g];

      snn_spike_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk (clk),
         .rst (rst),
         .clr (cnt_clr),
         .en  (cnt_en[g]),
         .cnt (cnt[g])
      );
   end

   // FSM next state and outputs
   always_comb begin
      nxt         = state;
      phase_last  = 1'b0;
      neuron_rst  = 1'b0;
      feat_hold   = 1'b0;
      busy        = 1'b1;
      class_valid = 1'b0;
      cnt_clr     = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (beat_start) begin
               nxt     = SETTLE;
               cnt_clr = 1'b1;
            end
         end
         SETTLE: begin
            neuron_rst = 1'b1;
            feat_hold  = 1'b1;
            phase_last = (phase == PH_W'(SETTLE_CYC - 1));
            if (phase_last) nxt = OBSERVE;
         end
         OBSERVE: begin
            feat_hold  = 1'b1;
            phase_last = (phase == PH_W'(WIN_CYCLES - 1));
            if (phase_last) nxt = DECIDE;
         end
         DECIDE: begin
            phase_last = (phase == PH_W'(N_CLASS - 1));
            if (phase_last) nxt = REPORT;
         end
         REPORT: begin
            class_valid = 1'b1;
            if (class_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Sequential argmax: during DECIDE, phase selects the counter under test.
   always_comb begin
      cur = '0;
      for (int unsigned i = 0; i < N_CLASS; i++) begin
         if (phase == PH_W'(i)) cur = cnt[i];
      end
      best_n     = best;
      best_idx_n = best_idx;
`ifdef SNN_SCHED_MARGIN_EN
      second_n   = second;
`endif
      if (cur > best) begin
         best_n     = cur;
         best_idx_n = CLS_W'(phase);
`ifdef SNN_SCHED_MARGIN_EN
         second_n   = best;
`endif
      end
`ifdef SNN_SCHED_MARGIN_EN
      else if (cur > second) begin
         second_n = cur;
      end
`endif
      win_ok = (best_n >= MIN_CNT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         phase       <= '0;
         best        <= '0;
         best_idx    <= '0;
         class_id    <= CLS_NONE;
         class_count <= '0;
         overrun     <= 1'b0;
      end else begin
         state <= nxt;
         if (phase_last || (state == IDLE) || (state == REPORT)) begin
            phase <= '0;
         end else begin
            phase <= phase + PH_W'(1);
         end

         if (beat_start && (state != IDLE)) overrun <= 1'b1;

         if (state == SETTLE) begin
            best     <= '0;
            best_idx <= '0;
         end else if (state == DECIDE) begin
            best     <= best_n;
            best_idx <= best_idx_n;
            // The last compare result is taken from best_n directly so the
            // result lands together with the move to REPORT.
            if (phase_last) begin
               class_id    <= win_ok ? best_idx_n : CLS_NONE;
               class_count <= best_n;
            end
         end
      end
   end

`ifdef SNN_SCHED_MARGIN_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         second       <= '0;
         class_margin <= '0;
      end else if (state == SETTLE) begin
         second <= '0;
      end else if (state == DECIDE) begin
         second <= second_n;
         if (phase_last) begin
            class_margin <= win_ok ? (best_n - second_n) : '0;
         end
      end
   end
`else
   assign class_margin = '0;
`endif

endmodule

// File: tb/tb_snn_beat_sched.sv
// Bench for snn_beat_sched: two instances share all inputs, a 12-bit counter
// build and a 3-bit counter build that exercises saturation.
module tb_snn_beat_sched;

   localparam int unsigned NC  = 9;
   localparam int unsigned SC  = 2;
   localparam int unsigned WC  = 16;
   localparam int unsigned CW  = 12;
   localparam int unsigned CWS = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          beat_start;
   logic [NC-1:0] spike_in;
   logic          class_ready;

   logic          neuron_rst, feat_hold, busy, class_valid, overrun;
   logic [3:0]    class_id;
   logic [CW-1:0] class_count, class_margin;

   logic           s_neuron_rst, s_feat_hold, s_busy, s_class_valid, s_overrun;
   logic [3:0]     s_class_id;
   logic [CWS-1:0] s_class_count, s_class_margin;

   always #5 clk = ~clk;

   snn_beat_sched #(
      .N_CLASS(NC), .SETTLE_CYC(SC), .WIN_CYCLES(WC), .CNT_W(CW), .MIN_SPIKES(1)
   ) dut (
      .clk(clk), .rst(rst), .beat_start(beat_start), .spike_in(spike_in),
      .neuron_rst(neuron_rst), .feat_hold(feat_hold), .busy(busy),
      .class_valid(class_valid), .class_ready(class_ready),
      .class_id(class_id), .class_count(class_count),
      .class_margin(class_margin), .overrun(overrun)
   );

   snn_beat_sched #(
      .N_CLASS(NC), .SETTLE_CYC(SC), .WIN_CYCLES(WC), .CNT_W(CWS), .MIN_SPIKES(1)
   ) dut_sat (
      .clk(clk), .rst(rst), .beat_start(beat_start), .spike_in(spike_in),
      .neuron_rst(s_neuron_rst), .feat_hold(s_feat_hold), .busy(s_busy),
      .class_valid(s_class_valid), .class_ready(class_ready),
      .class_id(s_class_id), .class_count(s_class_count),
      .class_margin(s_class_margin), .overrun(s_overrun)
   );

   int tests = 0;
   int fails = 0;
   logic ovr_exp = 1'b0;

   // settle_m: spikes driven outside the window (must be ignored)
   // me / mo : spikes on even / odd window cycles
   typedef struct {
      logic [NC-1:0] settle_m;
      logic [NC-1:0] me;
      logic [NC-1:0] mo;
      logic [3:0]    id;
      int unsigned   cnt;
      int unsigned   margin;
      logic [3:0]    sid;
      int unsigned   scnt;
   } vec_t;

   vec_t vecs[6];
   vec_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_beat(input vec_t v, input int hold, input bit poke);
      vec_t e;
      int n;
      logic [3:0] cid;
      logic [CW-1:0] ccnt, cmg;
      logic [31:0] exp_mg;
      class_ready = (hold == 0);
      @(posedge clk); #1;
      beat_start = 1'b1;
      spike_in   = '0;
      sb.push_back(v);
      @(posedge clk); #1;
      beat_start = 1'b0;
      spike_in   = v.settle_m;
      n = 0;
      check("settle_neuron_rst", neuron_rst, 1'b1);
      repeat (SC) begin @(posedge clk); n++; end
      for (int k = 0; k < WC; k++) begin
         #1;
         if (k == 0) begin
            check("observe_neuron_rst", neuron_rst, 1'b0);
            check("observe_feat_hold", feat_hold, 1'b1);
         end
         spike_in = (k % 2 == 0) ? v.me : v.mo;
         @(posedge clk); n++;
      end
      #1;
      spike_in = v.settle_m;
      check("decide_feat_hold", feat_hold, 1'b0);
      check("decide_busy", busy, 1'b1);
      while (!class_valid && n < 60) begin
         @(posedge clk); n++; #1;
      end
      check("latency", n + 1, SC + WC + NC + 1);
      e = sb.pop_front();
`ifdef SNN_SCHED_MARGIN_EN
      exp_mg = e.margin;
`else
      exp_mg = 0;
`endif
      check("valid", class_valid, 1'b1);
      check("class_id", class_id, e.id);
      check("class_count", class_count, e.cnt);
      check("class_margin", class_margin, exp_mg);
      check("sat_valid", s_class_valid, 1'b1);
      check("sat_class_id", s_class_id, e.sid);
      check("sat_class_count", s_class_count, e.scnt);
      cid  = class_id;
      ccnt = class_count;
      cmg  = class_margin;
      for (int h = 0; h < hold; h++) begin
         if (poke && h == 2) beat_start = 1'b1;
         @(posedge clk); #1;
         beat_start = 1'b0;
         check("hold_valid", class_valid, 1'b1);
         check("hold_id", class_id, cid);
         check("hold_count", class_count, ccnt);
         check("hold_margin", class_margin, cmg);
      end
      if (poke) ovr_exp = 1'b1;
      // Handshake cycle; with poke, a beat_start arrives in that same cycle.
      class_ready = 1'b1;
      beat_start  = poke;
      @(posedge clk); #1;
      beat_start = 1'b0;
      check("post_valid", class_valid, 1'b0);
      check("post_busy", busy, 1'b0);
      check("overrun", overrun, ovr_exp);
      if (poke) begin
         repeat (3) @(posedge clk);
         #1;
         check("no_new_beat", busy, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      //         settle    even      odd       id    cnt margin sid  scnt
      vecs[0] = '{9'h000, 9'h010, 9'h000, 4'd4, 8,  8,  4'd4, 7};
      vecs[1] = '{9'h000, 9'h042, 9'h042, 4'd1, 16, 0,  4'd1, 7};
      vecs[2] = '{9'h000, 9'h000, 9'h000, 4'hF, 0,  0,  4'hF, 0};
      vecs[3] = '{9'h1FF, 9'h000, 9'h000, 4'hF, 0,  0,  4'hF, 0};
      vecs[4] = '{9'h000, 9'h001, 9'h001, 4'd0, 16, 16, 4'd0, 7};
      vecs[5] = '{9'h000, 9'h108, 9'h100, 4'd8, 16, 8,  4'd3, 7};

      rst = 1'b1;
      beat_start = 1'b0;
      spike_in = '0;
      class_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", class_valid, 1'b0);
      check("rst_id", class_id, 4'hF);
      check("rst_count", class_count, '0);
      check("rst_margin", class_margin, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_neuron_rst", neuron_rst, 1'b0);
      check("rst_feat_hold", feat_hold, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_beat(vecs[i], 0, 1'b0);

      // Consumer stalls 5 cycles; beat_start pulses while stalled and at the handshake.
      run_beat(vecs[0], 5, 1'b1);

      // Reset in the middle of a window, then a clean beat.
      @(posedge clk); #1;
      beat_start = 1'b1;
      spike_in   = '0;
      @(posedge clk); #1;
      beat_start = 1'b0;
      repeat (SC) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         #1 spike_in = 9'h080;
         @(posedge clk);
      end
      #1 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_feat_hold", feat_hold, 1'b0);
      check("midrst_overrun", overrun, 1'b0);
      check("midrst_id", class_id, 4'hF);
      check("midrst_count", class_count, '0);
      @(posedge clk); #1;
      check("midrst_valid", class_valid, 1'b0);
      check("midrst_sat_count", s_class_count, '0);
      rst = 1'b0;
      spike_in = '0;
      ovr_exp = 1'b0;
      run_beat('{9'h000, 9'h004, 9'h004, 4'd2, 16, 16, 4'd2, 7}, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
